// File: rtl/combi_mem_arb_if.sv
// Request/response and memory bus of the combined-core memory arbiter.
// The arbiter uses the slave view; the core and the memory model use the master view.
interface combi_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_ready;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;

    logic            dm_req;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW/8-1:0] dm_be;
    logic            dm_ready;
    logic            dm_rvalid;
    logic [DW-1:0]   dm_rdata;

    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_ready, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_ready, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/combi_mem_arb.sv
// Single-port memory arbiter: data port has priority, fetch is forced through after
// MAX_DATA_RUN consecutive data grants, and the one outstanding read is routed back.
module combi_mem_arb #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input logic             clk,
    input logic             reset,
    combi_mem_arb_if.slave  bus
);
    localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

    logic [3:0] run_q, run_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;
    logic       dm_gnt, if_gnt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        dm_gnt        = 1'b0;
        if_gnt        = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        run_d         = run_q;

        if (!reset) begin
            dm_gnt = bus.dm_req && !(bus.if_req && run_q == MAX_RUN);
            if_gnt = bus.if_req && !dm_gnt;
        end

        if (dm_gnt) begin
            bus.mem_we    = bus.dm_we;
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
            bus.mem_be    = bus.dm_be;
        end else if (if_gnt) begin
            bus.mem_addr  = bus.if_addr;
            bus.mem_be    = '1;
        end
        bus.mem_en = dm_gnt | if_gnt;

        // Starvation count only grows while fetch is actually waiting.
        if (!bus.if_req || if_gnt)
            run_d = '0;
        else if (dm_gnt && run_q != MAX_RUN)
            run_d = run_q + 4'd1;

        rd_pend_d  = if_gnt | (dm_gnt & ~bus.dm_we);
        rd_owner_d = rd_pend_d ? dm_gnt : rd_owner_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            run_q      <= run_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.dm_ready  = dm_gnt;
    assign bus.if_ready  = if_gnt;
    assign bus.if_rvalid = rd_pend_q & ~rd_owner_q;
    assign bus.dm_rvalid = rd_pend_q &  rd_owner_q;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_combi_mem_arb.sv
// Self-checking bench for combi_mem_arb: directed scenarios plus randomized traffic
// compared against a rule-level reference model of grants and read ownership.
module tb_combi_mem_arb;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    combi_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    combi_mem_arb #(.AW(AW), .DW(DW), .MAX_DATA_RUN(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: starvation count and the read still awaiting its response.
    int   m_run   = 0;
    bit   m_pend  = 1'b0;
    bit   m_owner = 1'b0;
    bit   exp_dm, exp_if;
    logic obs_dm, obs_if, obs_dmv, obs_ifv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already applied; check at negedge, advance model at posedge.
    task automatic step();
        @(negedge clk);
        if (reset) begin
            m_run  = 0;
            m_pend = 1'b0;
        end
        exp_dm = !reset && bus.dm_req && !(bus.if_req && m_run == MAX);
        exp_if = !reset && bus.if_req && !exp_dm;

        obs_dm  = bus.dm_ready;
        obs_if  = bus.if_ready;
        obs_dmv = bus.dm_rvalid;
        obs_ifv = bus.if_rvalid;

        check("dm_ready",  bus.dm_ready, exp_dm);
        check("if_ready",  bus.if_ready, exp_if);
        check("mem_en",    bus.mem_en,   exp_dm | exp_if);
        check("mem_we",    bus.mem_we,   exp_dm & bus.dm_we);
        if (exp_dm) begin
            check("mem_addr_d",  bus.mem_addr,  bus.dm_addr);
            check("mem_wdata_d", bus.mem_wdata, bus.dm_wdata);
            check("mem_be_d",    bus.mem_be,    bus.dm_be);
        end else if (exp_if) begin
            check("mem_addr_f",  bus.mem_addr,  bus.if_addr);
            check("mem_wdata_f", bus.mem_wdata, 0);
            check("mem_be_f",    bus.mem_be,    4'hF);
        end
        check("if_rvalid", bus.if_rvalid, m_pend & !m_owner);
        check("dm_rvalid", bus.dm_rvalid, m_pend &  m_owner);
        if (m_pend && m_owner)  check("dm_rdata", bus.dm_rdata, bus.mem_rdata);
        if (m_pend && !m_owner) check("if_rdata", bus.if_rdata, bus.mem_rdata);

        @(posedge clk);
        if (!reset) begin
            m_pend = exp_if || (exp_dm && !bus.dm_we);
            if (m_pend) m_owner = exp_dm;
            if (!bus.if_req || exp_if) m_run = 0;
            else if (exp_dm && m_run < MAX) m_run = m_run + 1;
        end
        #1;
    endtask

    task automatic set_if(input logic req, input logic [AW-1:0] addr);
        bus.if_req  = req;
        bus.if_addr = addr;
    endtask

    task automatic set_dm(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [3:0] be);
        bus.dm_req   = req;
        bus.dm_we    = we;
        bus.dm_addr  = addr;
        bus.dm_wdata = wdata;
        bus.dm_be    = be;
    endtask

    logic [9:0] pattern;

    initial begin
        reset = 1'b1;
        bus.mem_rdata = '0;
        set_if(1'b1, 32'h10);
        set_dm(1'b1, 1'b0, 32'd96, '0, 4'hF);

        // Reset held with both requests up: nothing granted, nothing valid.
        step();
        step();
        check("rst_dm_ready", obs_dm, 1'b0);
        check("rst_if_ready", obs_if, 1'b0);

        reset = 1'b0;
        set_dm(1'b1, 1'b1, 32'd100, 32'd7, 4'hF);
        step();
        check("first_gnt_dm", obs_dm, 1'b1);
        check("first_no_rv",  obs_dmv | obs_ifv, 1'b0);

        // Write completes at grant, no response afterwards.
        set_if(1'b0, '0);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        step();
        check("wr_no_rvalid", obs_dmv | obs_ifv, 1'b0);

        // Fetch read with the instruction word returned next cycle.
        set_if(1'b1, 32'h10);
        step();
        check("fetch_gnt", obs_if, 1'b1);
        set_if(1'b0, '0);
        bus.mem_rdata = 32'hE280_2005;
        step();
        check("fetch_rvalid", obs_ifv, 1'b1);
        check("fetch_dmv",    obs_dmv, 1'b0);

        // Both ports held: grants follow D,D,D,D,F,D,D,D,D,F.
        set_if(1'b1, 32'h20);
        set_dm(1'b1, 1'b1, 32'd200, 32'hA5, 4'h3);
        for (int i = 0; i < 10; i++) begin
            bus.mem_rdata = $urandom;
            step();
            pattern[i] = obs_dm;
            if (obs_if) check("run_after_f", dut.run_q, 4'd0);
        end
        check("grant_pattern", pattern, 10'b01111_01111);

        // Alternating reads D(96), F(0x14), D(100).
        set_if(1'b0, '0);
        set_dm(1'b1, 1'b0, 32'd96, '0, 4'hF);
        step();
        set_dm(1'b0, 1'b0, '0, '0, '0);
        set_if(1'b1, 32'h14);
        bus.mem_rdata = 32'h1111_0001;
        step();
        check("alt_dm1", obs_dmv, 1'b1);
        set_if(1'b0, '0);
        set_dm(1'b1, 1'b0, 32'd100, '0, 4'hF);
        bus.mem_rdata = 32'h2222_0002;
        step();
        check("alt_if", obs_ifv, 1'b1);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        bus.mem_rdata = 32'h3333_0003;
        step();
        check("alt_dm2", obs_dmv, 1'b1);

        // Reset right after a data read grant discards the response.
        set_if(1'b1, 32'h30);
        set_dm(1'b1, 1'b0, 32'd104, '0, 4'hF);
        step();
        set_if(1'b0, '0);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        step();
        check("rst_mid_dmv", obs_dmv, 1'b0);
        reset = 1'b0;
        step();
        check("post_rst_dmv", obs_dmv, 1'b0);
        check("post_rst_run", dut.run_q, 4'd0);

        // Randomized traffic; pending requests stay stable until granted.
        for (int i = 0; i < 600; i++) begin
            if (!bus.if_req || exp_if)
                set_if($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC);
            if (!bus.dm_req || exp_dm)
                set_dm($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
            bus.mem_rdata = $urandom;
            reset = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/combi_mem_arb.md
# combi_mem_arb

Single-port memory arbiter for the combined ARM/RISC-V core. It shares one unified instruction/data memory between the core's instruction-fetch port and its data port. Data accesses have priority, and a bounded-starvation counter guarantees fetch progress. It tracks the one outstanding read and routes the returned word to its owner, so `combi` can run on a single memory macro.

## Interface
Parameters:
- `AW`, 32, address width (byte address).
- `DW`, 32, data width.
- `MAX_DATA_RUN`, 4, consecutive data grants allowed while fetch waits (range 1–15).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ready`.
- `if_addr`  in  AW  fetch byte address.
- `if_ready`  out  1  fetch granted this cycle (combinational).
- `if_rvalid`  out  1  `if_rdata` valid (registered).
- `if_rdata`  out  DW  fetched instruction.
- `dm_req`  in  1  data request; held with its qualifiers until `dm_ready`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  AW  data byte address.
- `dm_wdata`  in  DW  write data.
- `dm_be`  in  DW/8  byte enables for writes.
- `dm_ready`  out  1  data access granted this cycle (combinational).
- `dm_rvalid`  out  1  `dm_rdata` valid (registered).
- `dm_rdata`  out  DW  load data.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  AW  memory byte address (memory ignores bits [1:0]).
- `mem_wdata`  out  DW  memory write data.
- `mem_be`  out  DW/8  memory byte enables.
- `mem_rdata`  in  DW  read data, valid the cycle after a read grant.

## Operation
- Grant decision is combinational each cycle from `if_req`, `dm_req` and `run_q`. There is at most one grant per cycle.
- `run_q` is a 4-bit count of consecutive data grants taken while `if_req` was high.
- Grant rules:
  - Data is granted if `dm_req` and not (`if_req` and `run_q == MAX_DATA_RUN`).
  - Fetch is granted if `if_req` and data is not granted.
- `run_q` update:
  - Clears when fetch is granted or `if_req == 0`.
  - Increments on a data grant with `if_req == 1`.
  - Saturates at `MAX_DATA_RUN`.
- Memory drive on a data grant:
  - `mem_en=1`, `mem_we=dm_we`, `mem_addr=dm_addr`, `mem_wdata=dm_wdata`, `mem_be=dm_be`.
- Memory drive on a fetch grant:
  - `mem_en=1`, `mem_we=0`, `mem_addr=if_addr`, `mem_be` all ones, `mem_wdata=0`.
- No grant: `mem_en=0`, `mem_we=0`; other memory outputs are don't-care.
- Read-owner register: on any read grant, `rd_pend_q<=1` and `rd_owner_q<=granted port` (0 = fetch, 1 = data). Otherwise `rd_pend_q<=0`.
- Response routing:
  - `if_rvalid = rd_pend_q & ~rd_owner_q`.
  - `dm_rvalid = rd_pend_q & rd_owner_q`.
  - Both rdata outputs are driven straight from `mem_rdata`.
- Writes produce no rvalid. A write completes at grant.
- Requests are never dropped. An ungranted request stays pending with ready low, and its fields must stay stable.

## Timing
- Reset values: `run_q=0`, `rd_pend_q=0`, `rd_owner_q=0`. Hence `if_rvalid=0`, `dm_rvalid=0`, and `mem_en=mem_we=0` while `reset` is high; ready outputs are 0 during reset.
- Reset mid-read: the pending response is discarded. No rvalid appears after reset deasserts.
- Read latency: grant in cycle N gives rvalid and rdata in cycle N+1.
- Throughput: one access per cycle. Back-to-back reads from alternating ports each get the correct owner.
- Simultaneous `if_req` and `dm_req`: data wins unless `run_q == MAX_DATA_RUN`.
- Worst-case fetch wait: `MAX_DATA_RUN` cycles, then the fetch is granted in cycle `MAX_DATA_RUN + 1`.
- A `dm_req` that arrives in the fetch-forced cycle waits exactly one cycle.
- Ready is combinational from request inputs and `run_q`. There is no combinational path from `mem_rdata` to any ready.

## Test plan
- Reset held with `if_req=dm_req=1` -> `mem_en=0`, both ready 0. After release, first grant is data, and `if_rvalid`/`dm_rvalid` stay 0 in the first cycle.
- Data write `dm_addr=100`, `dm_wdata=7`, `dm_be=4'hF` with `if_req=1` -> same cycle `dm_ready=1`, `mem_we=1`, `mem_addr=100`, `mem_wdata=7`. No rvalid the next cycle.
- Fetch read `if_addr=0x10`, memory returns 0xE2802005 -> `if_ready` in cycle N, then in cycle N+1 `if_rvalid=1`, `if_rdata=0xE2802005`, `dm_rvalid=0`.
- `dm_req` and `if_req` held continuously with `MAX_DATA_RUN=4` -> grants go D,D,D,D,F,D,D,D,D,F. `run_q` returns to 0 after each F.
- Alternating read grants D(96), F(0x14), D(100) -> rvalid pattern dm, if, dm on the following cycles, each carrying that cycle's `mem_rdata`.
- Reset asserted the cycle after a data read grant -> `dm_rvalid` never asserts, and `run_q` is 0 after release.
